arrow_scheduler: RTL and testbench
==================================

ARROW_SCHEDULER -- requirements
Module: arrow_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_SLOTS, default 8: number of arrow instances it drives.
REQ-002 The block SHALL have parameter MAX_ENTRIES, default 24: maximum pattern entries per phase.
REQ-003 The block SHALL have parameter TICK_DIV, default 6500000: clk cycles per timing tick.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start_in, input, 1 bit: single-cycle pulse that begins a phase.
REQ-007 The block SHALL have port abort_in, input, 1 bit: level signal that ends a phase immediately.
REQ-008 The block SHALL have port entry_addr_out, output, 5 bits: pattern entry index.
REQ-009 The block SHALL have port entry_in, input, 8 bits: {timing[7:5], dir[4:3], speed[2:1], inv[0]}, valid one cycle after entry_addr_out changes.
REQ-010 The block SHALL have port slot_busy_in, input, NUM_SLOTS bits: valid_out of each arrow.
REQ-011 The block SHALL have port launch_out, output, NUM_SLOTS bits: one-hot, single-cycle valid_in pulse.
REQ-012 The block SHALL have port launch_dir_out, output, 2 bits: direction of the current launch.
REQ-013 The block SHALL have port launch_speed_out, output, 2 bits: speed of the current launch.
REQ-014 The block SHALL have port launch_inv_out, output, 1 bit: inversed flag of the current launch.
REQ-015 The block SHALL have port busy_out, output, 1 bit: high while a phase is running.
REQ-016 The block SHALL have port finished_out, output, 1 bit: one-cycle pulse at normal phase end.

Function
REQ-017 The state machine SHALL have the states IDLE, FETCH, WAIT, LAUNCH, STALL, DRAIN and DONE.
REQ-018 IDLE with start_in=1 SHALL set entry_addr_out=0 and go to FETCH; start_in outside IDLE SHALL be ignored.
REQ-019 FETCH SHALL last exactly one cycle, then latch entry_in; if timing==0 go to DRAIN, else clear the tick counters and go to WAIT.
REQ-020 WAIT SHALL count timing*TICK_DIV clk cycles, then go to LAUNCH if a free slot exists, else to STALL.
REQ-021 The free mask SHALL equal ~slot_busy_in & ~reserved; LAUNCH SHALL select the lowest-index free bit.
REQ-022 LAUNCH SHALL last one cycle: launch_out one-hot set and dir/speed/inv driven from the latched entry, all registered; the selected reserved bit set.
REQ-023 After LAUNCH, entry_addr_out SHALL increment and the state go to FETCH; if the launched entry index was MAX_ENTRIES-1, it SHALL go to DRAIN instead, with no wrap-around.
REQ-024 A reserved bit SHALL clear on the first cycle its slot_busy_in bit is 1.
REQ-025 STALL SHALL move to LAUNCH on the first cycle any slot is free, with no additional tick wait.
REQ-026 DRAIN SHALL go to DONE when slot_busy_in==0 and reserved==0.
REQ-027 DONE SHALL last one cycle with finished_out=1 and busy_out=0, then go to IDLE.
REQ-028 busy_out SHALL be 1 in FETCH, WAIT, LAUNCH, STALL and DRAIN, and 0 otherwise.
REQ-029 launch_out SHALL be 0 in every state except LAUNCH.
REQ-030 abort_in=1 in any state SHALL force IDLE next cycle, with no launch, no finished_out pulse, and reserved cleared; abort_in has priority over start_in.
REQ-031 Tick arithmetic SHALL use at least 32 bits, with no overflow for timing=7 and the default TICK_DIV.

Reset
REQ-032 When rst=0, all outputs SHALL be 0, state=IDLE, entry_addr_out=0, reserved=0 and the counters=0.
REQ-033 Reset asserted mid-phase SHALL abandon the phase with no finished_out pulse.

Configuration
REQ-034 With SCHED_STATS_EN defined, the block SHALL add outputs launch_count_out (8 bits) and stall_cycles_out (16 bits), cleared on a start_in accept; stall_cycles_out SHALL saturate at 16'hFFFF.
REQ-035 With SCHED_STATS_EN undefined, those ports and their counters SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-036 Bench with TICK_DIV=4, timings 1,1,1,0, slots idle -> launch_out 8'h01, 8'h02, 8'h04, then DRAIN; busy_in cleared -> one finished_out pulse.
REQ-037 Bench with all 8 slots busy when WAIT expires -> STALL, no launch; free slot 5 -> launch_out=8'h20 on the next cycle.
REQ-038 Bench with launch to slot 0 and busy_in[0] delayed 3 cycles, second launch due -> second launch to slot 1, not slot 0.
REQ-039 Bench with abort_in during WAIT -> IDLE next cycle, busy_out=0, no launch, no finished_out; a new start_in is accepted.
REQ-040 Bench with MAX_ENTRIES=2 and no zero-timing entry -> exactly 2 launches, then DRAIN and finished_out; entry_addr_out never exceeds 1.
REQ-041 Bench with rst pulled low during LAUNCH -> launch_out=0 immediately and all outputs 0.

Source files
------------

// File: rtl/arrow_scheduler.sv
// Arrow launch scheduler: walks a pattern table, waits each entry's tick delay and
// launches it into the lowest free arrow slot. Optional stats outputs: SCHED_STATS_EN.
module arrow_scheduler #(
    parameter int unsigned NUM_SLOTS   = 8,
    parameter int unsigned MAX_ENTRIES = 24,
    parameter int unsigned TICK_DIV    = 6500000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_in,
    input  logic                 abort_in,
    output logic [4:0]           entry_addr_out,
    input  logic [7:0]           entry_in,
    input  logic [NUM_SLOTS-1:0] slot_busy_in,
    output logic [NUM_SLOTS-1:0] launch_out,
    output logic [1:0]           launch_dir_out,
    output logic [1:0]           launch_speed_out,
    output logic                 launch_inv_out,
    output logic                 busy_out,
    output logic                 finished_out
`ifdef SCHED_STATS_EN
    ,
    output logic [7:0]           launch_count_out,
    output logic [15:0]          stall_cycles_out
`endif
);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, LAUNCH, STALL, DRAIN, DONE} state_t;

    localparam logic [4:0]  LAST_ADDR  = 5'(MAX_ENTRIES - 1);
    localparam logic [31:0] TICK_DIV_W = 32'(TICK_DIV);

    state_t               state_q, state_d;
    logic [4:0]           addr_q, addr_d;
    logic [31:0]          wait_cnt_q, wait_cnt_d;
    logic [4:0]           entry_q, entry_d;
    logic [NUM_SLOTS-1:0] reserved_q, reserved_d;
    logic [NUM_SLOTS-1:0] launch_q, launch_d;
    logic [1:0]           dir_q, dir_d;
    logic [1:0]           speed_q, speed_d;
    logic                 inv_q, inv_d;
    logic                 busy_q, busy_d;
    logic                 fin_q, fin_d;
    logic [NUM_SLOTS-1:0] free_mask;
    logic [NUM_SLOTS-1:0] pick;
    logic                 found;

    // A launched slot stays reserved until its arrow reports busy, covering the gap
    // between valid_in and valid_out.
    always_comb begin
        free_mask = ~slot_busy_in & ~reserved_q;
        pick      = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (free_mask[i] && !found) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wait_cnt_d = wait_cnt_q;
        entry_d    = entry_q;
        reserved_d = reserved_q & ~slot_busy_in;
        launch_d   = '0;
        dir_d      = '0;
        speed_d    = '0;
        inv_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    addr_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                entry_d = entry_in[4:0];
                if (entry_in[7:5] == 3'd0) begin
                    state_d = DRAIN;
                end else begin
                    wait_cnt_d = 32'(entry_in[7:5]) * TICK_DIV_W - 32'd1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt_q != '0) begin
                    wait_cnt_d = wait_cnt_q - 32'd1;
                end else if (found) begin
                    state_d = LAUNCH;
                end else begin
                    state_d = STALL;
                end
            end
            STALL: begin
                if (found) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end else begin
                    addr_d  = addr_q + 5'd1;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (slot_busy_in == '0 && reserved_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort_in) begin
            state_d    = IDLE;
            reserved_d = '0;
            wait_cnt_d = '0;
        end

        if (state_d == LAUNCH) begin
            launch_d   = pick;
            reserved_d = reserved_d | pick;
            dir_d      = entry_q[4:3];
            speed_d    = entry_q[2:1];
            inv_d      = entry_q[0];
        end

        busy_d = (state_d inside {FETCH, WAIT, LAUNCH, STALL, DRAIN});
        fin_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wait_cnt_q <= '0;
            entry_q    <= '0;
            reserved_q <= '0;
            launch_q   <= '0;
            dir_q      <= '0;
            speed_q    <= '0;
            inv_q      <= 1'b0;
            busy_q     <= 1'b0;
            fin_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wait_cnt_q <= wait_cnt_d;
            entry_q    <= entry_d;
            reserved_q <= reserved_d;
            launch_q   <= launch_d;
            dir_q      <= dir_d;
            speed_q    <= speed_d;
            inv_q      <= inv_d;
            busy_q     <= busy_d;
            fin_q      <= fin_d;
        end
    end

    assign entry_addr_out   = addr_q;
    assign launch_out       = launch_q;
    assign launch_dir_out   = dir_q;
    assign launch_speed_out = speed_q;
    assign launch_inv_out   = inv_q;
    assign busy_out         = busy_q;
    assign finished_out     = fin_q;

`ifdef SCHED_STATS_EN
    logic [7:0]  launch_cnt_q, launch_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        launch_cnt_d = launch_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (state_q == IDLE && state_d == FETCH) begin
            launch_cnt_d = '0;
            stall_cnt_d  = '0;
        end else begin
            if (state_d == LAUNCH) begin
                launch_cnt_d = launch_cnt_q + 8'd1;
            end
            if (state_q == STALL && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            launch_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            launch_cnt_q <= launch_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign launch_count_out = launch_cnt_q;
    assign stall_cycles_out = stall_cnt_q;
`endif

endmodule

// File: tb/tb_arrow_scheduler.sv
// Self-checking bench for arrow_scheduler: directed scenarios plus random phases,
// compared cycle by cycle against a phase-level reference model.
module tb_arrow_scheduler;
    localparam int TD = 4;
    localparam int NS = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, abort, sel;
    logic [7:0] slot_busy;
    logic [7:0] rom [32];

    logic       start_a, start_b;
    logic [4:0] addr_a, addr_b;
    logic [7:0] entry_a, entry_b;
    logic [7:0] launch_a, launch_b;
    logic [1:0] dir_a, dir_b, speed_a, speed_b;
    logic       inv_a, inv_b, busy_a, busy_b, fin_a, fin_b;

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign entry_a = rom[addr_a];
    assign entry_b = rom[addr_b];

    arrow_scheduler #(.NUM_SLOTS(NS), .MAX_ENTRIES(24), .TICK_DIV(TD)) u_dut_a (
        .clk(clk), .rst(rst), .start_in(start_a), .abort_in(abort),
        .entry_addr_out(addr_a), .entry_in(entry_a), .slot_busy_in(slot_busy),
        .launch_out(launch_a), .launch_dir_out(dir_a), .launch_speed_out(speed_a),
        .launch_inv_out(inv_a), .busy_out(busy_a), .finished_out(fin_a)
    );

    arrow_scheduler #(.NUM_SLOTS(NS), .MAX_ENTRIES(2), .TICK_DIV(TD)) u_dut_b (
        .clk(clk), .rst(rst), .start_in(start_b), .abort_in(abort),
        .entry_addr_out(addr_b), .entry_in(entry_b), .slot_busy_in(slot_busy),
        .launch_out(launch_b), .launch_dir_out(dir_b), .launch_speed_out(speed_b),
        .launch_inv_out(inv_b), .busy_out(busy_b), .finished_out(fin_b)
    );

    logic [7:0] obs_launch;
    logic [1:0] obs_dir, obs_speed;
    logic       obs_inv, obs_busy, obs_fin;
    logic [4:0] obs_addr;
    assign obs_launch = sel ? launch_b : launch_a;
    assign obs_dir    = sel ? dir_b : dir_a;
    assign obs_speed  = sel ? speed_b : speed_a;
    assign obs_inv    = sel ? inv_b : inv_a;
    assign obs_busy   = sel ? busy_b : busy_a;
    assign obs_fin    = sel ? fin_b : fin_a;
    assign obs_addr   = sel ? addr_b : addr_a;

    // Reference model: phase position only; stalls fold into "waiting past due".
    typedef enum {M_IDLE, M_FETCH, M_WAIT, M_LAUNCHED, M_DRAIN, M_DONE} mmode_t;
    mmode_t     m;
    int         m_idx, m_due, max_e;
    logic [7:0] exp_launch;
    logic [1:0] exp_dir, exp_speed;
    logic       exp_inv, exp_busy, exp_fin;

    // Arrow environment: a slot is unavailable from launch until its busy window ends.
    int         n;
    bit         launched [NS];
    int         bstart [NS];
    int         bend [NS];
    logic [7:0] forced, unav;
    int         dly, len;

    logic [7:0] lq [$];
    int         nfin;
    int         checks, fails;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] lq_at(input int i);
        if (lq.size() > i) return lq[i];
        return 8'h00;
    endfunction

    task automatic update_env();
        logic [7:0] b;
        logic [7:0] f;
        b = forced;
        f = forced;
        for (int i = 0; i < NS; i++) begin
            if (launched[i]) begin
                if (n >= bstart[i] && n < bend[i]) b[i] = 1'b1;
                if (n < bend[i]) f[i] = 1'b1;
                else launched[i] = 1'b0;
            end
        end
        slot_busy = b;
        unav      = f;
    endtask

    task automatic model_eval();
        int e, t, slot;
        bit found;
        e = n + 1;
        max_e = sel ? 2 : 24;
        exp_launch = '0;
        exp_fin = 1'b0;
        if (abort) begin
            m = M_IDLE;
        end else begin
            case (m)
                M_IDLE: if (start) begin m = M_FETCH; m_idx = 0; end
                M_FETCH: begin
                    t = int'(rom[m_idx][7:5]);
                    if (t == 0) m = M_DRAIN;
                    else begin m = M_WAIT; m_due = e + t * TD; end
                end
                M_WAIT: begin
                    if (e >= m_due) begin
                        found = 1'b0;
                        slot = 0;
                        for (int i = 0; i < NS; i++) begin
                            if (!found && !unav[i]) begin found = 1'b1; slot = i; end
                        end
                        if (found) begin
                            exp_launch[slot] = 1'b1;
                            exp_dir   = rom[m_idx][4:3];
                            exp_speed = rom[m_idx][2:1];
                            exp_inv   = rom[m_idx][0];
                            m = M_LAUNCHED;
                        end
                    end
                end
                M_LAUNCHED: begin
                    if (m_idx == max_e - 1) m = M_DRAIN;
                    else begin m_idx++; m = M_FETCH; end
                end
                M_DRAIN: if (unav == 8'h00) begin m = M_DONE; exp_fin = 1'b1; end
                default: m = M_IDLE;
            endcase
        end
        exp_busy = (m == M_FETCH) || (m == M_WAIT) || (m == M_LAUNCHED) || (m == M_DRAIN);
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
        n++;
        chk("launch", 32'(obs_launch), 32'(exp_launch));
        chk("busy", 32'(obs_busy), 32'(exp_busy));
        chk("finished", 32'(obs_fin), 32'(exp_fin));
        chk("addr_range", 32'(int'(obs_addr) <= max_e - 1), 32'd1);
        if (exp_launch != 8'h00) begin
            chk("dir", 32'(obs_dir), 32'(exp_dir));
            chk("speed", 32'(obs_speed), 32'(exp_speed));
            chk("inv", 32'(obs_inv), 32'(exp_inv));
        end
        if (exp_busy) chk("addr", 32'(obs_addr), 32'(m_idx));
        if (obs_launch != 8'h00) begin
            lq.push_back(obs_launch);
            for (int i = 0; i < NS; i++) begin
                if (obs_launch[i]) begin
                    launched[i] = 1'b1;
                    bstart[i]   = n + dly;
                    bend[i]     = n + dly + len;
                end
            end
        end
        if (obs_fin) nfin++;
        update_env();
    endtask

    task automatic pulse_start();
        lq.delete();
        nfin = 0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_to_idle(input int limit);
        int k;
        k = 0;
        while (m != M_IDLE && k < limit) begin
            step();
            k++;
        end
        chk("phase_end_in_budget", 32'(m == M_IDLE), 32'd1);
    endtask

    initial begin
        int k, nent;
        rst = 1'b0; start = 1'b0; abort = 1'b0; sel = 1'b0;
        forced = 8'h00; dly = 1; len = 2; n = 0; m = M_IDLE; m_idx = 0; m_due = 0;
        max_e = 24; checks = 0; fails = 0; nfin = 0;
        exp_dir = '0; exp_speed = '0; exp_inv = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        for (int i = 0; i < NS; i++) begin launched[i] = 1'b0; bstart[i] = 0; bend[i] = 0; end
        update_env();

        #1;
        chk("rst_launch", 32'(launch_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_fin", 32'(fin_a), 32'd0);
        chk("rst_addr", 32'(addr_a), 32'd0);
        chk("rst_dir", 32'(dir_a), 32'd0);
        chk("rst_speed", 32'(speed_a), 32'd0);
        chk("rst_inv", 32'(inv_a), 32'd0);
        chk("rst_launch_b", 32'(launch_b), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) step();

        // Three unit-timing entries then terminator; arrows report late
        dly = 30; len = 3;
        rom[0] = {3'd1, 5'b01010}; rom[1] = {3'd1, 5'b10101};
        rom[2] = {3'd1, 5'b11001}; rom[3] = 8'h00;
        pulse_start();
        run_to_idle(200);
        chk("t1_nlaunch", 32'(lq.size()), 32'd3);
        chk("t1_l0", 32'(lq_at(0)), 32'h01);
        chk("t1_l1", 32'(lq_at(1)), 32'h02);
        chk("t1_l2", 32'(lq_at(2)), 32'h04);
        chk("t1_fin", 32'(nfin), 32'd1);

        // All slots busy at expiry, then only slot 5 frees
        dly = 2; len = 3;
        rom[0] = {3'd1, 5'b00111}; rom[1] = 8'h00;
        forced = 8'hFF; update_env();
        pulse_start();
        repeat (8) step();
        chk("t2_stall_nolaunch", 32'(lq.size()), 32'd0);
        forced = 8'hDF; update_env();
        step();
        chk("t2_stall_exit", 32'(lq.size()), 32'd1);
        chk("t2_slot5", 32'(lq_at(0)), 32'h20);
        forced = 8'h00; update_env();
        run_to_idle(100);
        chk("t2_fin", 32'(nfin), 32'd1);

        // Reserved slot 0 across the launch-to-busy gap
        rom[0] = {3'd1, 5'b10011}; rom[1] = {3'd1, 5'b01100}; rom[2] = 8'h00;
        dly = 3; len = 8;
        pulse_start();
        run_to_idle(150);
        chk("t3a_nlaunch", 32'(lq.size()), 32'd2);
        chk("t3a_l0", 32'(lq_at(0)), 32'h01);
        chk("t3a_l1", 32'(lq_at(1)), 32'h02);
        dly = 8; len = 4;
        pulse_start();
        run_to_idle(150);
        chk("t3b_l0", 32'(lq_at(0)), 32'h01);
        chk("t3b_l1", 32'(lq_at(1)), 32'h02);

        // Abort during WAIT, abort beating start, then a clean restart
        dly = 2; len = 2;
        rom[0] = {3'd3, 5'b11110}; rom[1] = 8'h00;
        pulse_start();
        repeat (4) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_busy_after_abort", 32'(busy_a), 32'd0);
        repeat (3) step();
        chk("t4_no_launch", 32'(lq.size()), 32'd0);
        chk("t4_no_fin", 32'(nfin), 32'd0);
        abort = 1'b1; start = 1'b1;
        step();
        abort = 1'b0; start = 1'b0;
        chk("t4_abort_prio", 32'(busy_a), 32'd0);
        pulse_start();
        run_to_idle(100);
        chk("t4_restart_launch", 32'(lq.size()), 32'd1);
        chk("t4_restart_fin", 32'(nfin), 32'd1);

        // Two-entry table with no terminator
        sel = 1'b1; dly = 1; len = 2;
        for (int i = 0; i < 4; i++) rom[i] = {3'd1, 5'(i * 7 + 3)};
        pulse_start();
        run_to_idle(100);
        chk("t5_nlaunch", 32'(lq.size()), 32'd2);
        chk("t5_fin", 32'(nfin), 32'd1);
        sel = 1'b0;
        step();

        // Reset mid-launch
        dly = 5; len = 3;
        rom[0] = {3'd1, 5'b11111}; rom[1] = {3'd1, 5'b11111}; rom[2] = 8'h00;
        pulse_start();
        k = 0;
        while (lq.size() == 0 && k < 20) begin step(); k++; end
        chk("t6_reached_launch", 32'(lq.size()), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_launch", 32'(launch_a), 32'd0);
        chk("t6_busy", 32'(busy_a), 32'd0);
        chk("t6_fin", 32'(fin_a), 32'd0);
        chk("t6_addr", 32'(addr_a), 32'd0);
        chk("t6_dir", 32'(dir_a), 32'd0);
        chk("t6_speed", 32'(speed_a), 32'd0);
        chk("t6_inv", 32'(inv_a), 32'd0);
        m = M_IDLE;
        for (int i = 0; i < NS; i++) launched[i] = 1'b0;
        forced = 8'h00; update_env();
        lq.delete(); nfin = 0;
        repeat (3) step();
        rst = 1'b1;
        repeat (4) step();
        chk("t6_no_fin", 32'(nfin), 32'd0);
        chk("t6_no_launch", 32'(lq.size()), 32'd0);

        // Random phases; the last one runs the full table length
        for (int ph = 0; ph < 6; ph++) begin
            dly = $urandom_range(1, 12);
            len = $urandom_range(1, 6);
            nent = (ph == 5) ? 24 : $urandom_range(1, 6);
            for (int i = 0; i < 32; i++) rom[i] = {3'($urandom_range(1, 3)), 5'($urandom)};
            if (nent < 24) rom[nent] = {3'd0, 5'($urandom)};
            pulse_start();
            run_to_idle(800);
            chk("rand_nlaunch", 32'(lq.size()), 32'(nent));
            chk("rand_fin", 32'(nfin), 32'd1);
            repeat ($urandom_range(0, 3)) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
